// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: synchronizer, debounce, one-shot push, optional auto-repeat.
// Optional feature macro: BUTTON_AUTOREPEAT_EN (auto-repeat pushes while a button is held).
module button_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd25000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_inc,
  input  logic button_dec,
  output logic inc_level,
  output logic dec_level,
  output logic push_inc,
  output logic push_dec
);

  localparam int unsigned NCH   = 2;
  localparam int unsigned DB_W  = 16;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned RPT_W = 24;
  localparam logic [RPT_W-1:0] DELAY_LAST  = REPEAT_DELAY - 24'd1;
  localparam logic [RPT_W-1:0] PERIOD_LAST = REPEAT_PERIOD - 24'd1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, REPEAT = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;
`endif

  logic [NCH-1:0] raw;
  logic [NCH-1:0] level;
  logic [NCH-1:0] req_c;

  assign raw = {button_dec, button_inc};

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic            sync1;
    logic            s;
    logic            lvl;
    logic [DB_W-1:0] db_cnt;
    logic            hit_c;
    logic            rise_c;
    logic            fall_c;
    logic            req;
    state_t          state;
    state_t          state_next;

    // Two-flop synchronizer
    always_ff @(posedge clk) begin
      if (!reset) begin
        sync1 <= 1'b0;
        s     <= 1'b0;
      end else begin
        sync1 <= raw[ch];
        s     <= sync1;
      end
    end

    assign hit_c  = (s != lvl) && (db_cnt == DEBOUNCE_CYCLES);
    assign rise_c = hit_c && !lvl;
    assign fall_c = hit_c && lvl;

    // Debounce: any cycle with s matching the level restarts the count
    always_ff @(posedge clk) begin
      if (!reset) begin
        db_cnt <= '0;
        lvl    <= 1'b0;
      end else if (s == lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DEBOUNCE_CYCLES) begin
        db_cnt <= '0;
        lvl    <= ~lvl;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
    end

`ifdef BUTTON_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_cnt;

    // Repeat timer restarts on every transition and every emitted push
    always_ff @(posedge clk) begin
      if (!reset) begin
        rpt_cnt <= '0;
      end else if ((state_next != state) || req || (state == IDLE)) begin
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
`endif

    always_comb begin
      state_next = state;
      req        = 1'b0;
      case (state)
        IDLE: begin
          if (rise_c) begin
            state_next = ARMED;
            req        = 1'b1;
          end
        end
        ARMED: begin
          if (fall_c) begin
            state_next = IDLE;
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (rpt_cnt == DELAY_LAST) begin
            state_next = REPEAT;
            req        = 1'b1;
          end
        end
        REPEAT: begin
          if (fall_c) begin
            state_next = IDLE;
          end else if (rpt_cnt == PERIOD_LAST) begin
            req = 1'b1;
          end
`endif
        end
        default: state_next = IDLE;
      endcase
    end

    assign level[ch] = lvl;
    assign req_c[ch] = req;
  end

  // Simultaneous requests cancel each other for that cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      push_inc <= 1'b0;
      push_dec <= 1'b0;
    end else begin
      push_inc <= req_c[0] & ~req_c[1];
      push_dec <= req_c[1] & ~req_c[0];
    end
  end

  assign inc_level = level[0];
  assign dec_level = level[1];

endmodule
